// File: rtl/shift_exec_stage.sv
// RV64 execute-stage shift unit: SLL/SRL/SRA and W-variants with one-cycle latency,
// valid/ready handshakes, a main output register plus one skid entry, and pipeline flush.
module shift_exec_stage #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6,
  parameter int RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_err
);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLW = 3'b100;
  localparam logic [2:0] OP_SRLW = 3'b101;
  localparam logic [2:0] OP_SRAW = 3'b110;

  logic [XLEN-1:0] calc_result;
  logic            calc_err;
  logic [31:0]     word;

  logic            skid_valid;
  logic [XLEN-1:0] skid_result;
  logic [RD_W-1:0] skid_rd;
  logic            skid_err;

  logic            accept;
  logic            drain;

  // Shift amounts above the low 6 bits never matter.
  logic unused_rs2;
  assign unused_rs2 = ^in_rs2[XLEN-1:SHAMT_W];

  // W ops shift the low word and sign-extend the 32-bit result from bit 31.
  always_comb begin
    calc_result = '0;
    calc_err    = 1'b0;
    word        = '0;
    case (in_op)
      OP_SLL:  calc_result = in_rs1 << in_rs2[SHAMT_W-1:0];
      OP_SRL:  calc_result = in_rs1 >> in_rs2[SHAMT_W-1:0];
      OP_SRA:  calc_result = $signed(in_rs1) >>> in_rs2[SHAMT_W-1:0];
      OP_SLLW: begin
        word        = in_rs1[31:0] << in_rs2[4:0];
        calc_result = {{(XLEN-32){word[31]}}, word};
      end
      OP_SRLW: begin
        word        = in_rs1[31:0] >> in_rs2[4:0];
        calc_result = {{(XLEN-32){word[31]}}, word};
      end
      OP_SRAW: begin
        word        = $signed(in_rs1[31:0]) >>> in_rs2[4:0];
        calc_result = {{(XLEN-32){word[31]}}, word};
      end
      default: calc_err = 1'b1;
    endcase
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Accept while skid is full is impossible, so a drain with a full skid never sees a new op.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_err     <= 1'b0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_rd     <= '0;
      skid_err    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        out_result <= skid_result;
        out_rd     <= skid_rd;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_result <= calc_result;
        out_rd     <= in_rd;
        out_err    <= calc_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= calc_result;
        out_rd     <= in_rd;
        out_err    <= calc_err;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_result <= calc_result;
      skid_rd     <= in_rd;
      skid_err    <= calc_err;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vector table, hand-built
// backpressure/flush/reset sequences, and randomized traffic against a queue model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] exp_result;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  vec_t vecs[14];
  exp_t model_q[$];

  shift_exec_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [4:0] rd);
    in_valid = v;
    in_op    = op;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference shifts from arithmetic: left shift = multiply by 2^sh, right shift =
  // divide, arithmetic right of a negative value = complement of divided complement.
  function automatic exp_t refShift(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b, input logic [4:0] rd);
    exp_t        e;
    logic [63:0] p6;
    logic [31:0] p5;
    logic [31:0] w;
    logic [31:0] lo;
    p6       = 64'd1 << b[5:0];
    p5       = 32'd1 << b[4:0];
    lo       = a[31:0];
    w        = '0;
    e.rd     = rd;
    e.err    = 1'b0;
    e.result = '0;
    case (op)
      3'b000: e.result = a * p6;
      3'b001: e.result = a / p6;
      3'b010: e.result = a[63] ? ~((~a) / p6) : a / p6;
      3'b100: w = lo * p5;
      3'b101: w = lo / p5;
      3'b110: w = lo[31] ? ~((~lo) / p5) : lo / p5;
      default: e.err = 1'b1;
    endcase
    if (op[2] && !e.err) e.result = {{32{w[31]}}, w};
    return e;
  endfunction

  initial begin
    vecs[0]  = '{3'b000, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 1'b0};
    vecs[1]  = '{3'b010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0};
    vecs[2]  = '{3'b001, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0};
    vecs[3]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[4]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'h0000_0000_4000_0000, 1'b0};
    vecs[5]  = '{3'b110, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1'b0};
    vecs[6]  = '{3'b100, 64'h1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[7]  = '{3'b011, 64'h5, 64'd2, 64'h0, 1'b1};
    vecs[8]  = '{3'b111, 64'hFFFF, 64'd1, 64'h0, 1'b1};
    vecs[9]  = '{3'b000, 64'h1234_5678_9ABC_DEF0, 64'hFFC0, 64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[10] = '{3'b100, 64'h1_7FFF_FFFF, 64'h20, 64'h0000_0000_7FFF_FFFF, 1'b0};
    vecs[11] = '{3'b110, 64'h7000_0000, 64'h3F, 64'h0, 1'b0};
    vecs[12] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h1, 1'b0};
    vecs[13] = '{3'b010, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 3'b000, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset out_result", out_result, 64'd0);
    checkOutput("reset out_rd", {59'd0, out_rd}, 64'd0);
    checkOutput("reset out_err", {63'd0, out_err}, 64'd0);

    // Directed table, back-to-back with the consumer always ready.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, 5'(i));
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid", i), {63'd0, out_valid}, 64'd1);
      checkOutput($sformatf("vec%0d result", i), out_result, vecs[i].exp_result);
      checkOutput($sformatf("vec%0d err", i), {63'd0, out_err}, {63'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d rd", i), {59'd0, out_rd}, {59'd0, 5'(i)});
    end
    applyStimulus(1'b0, 3'b000, '0, '0, '0);
    @(negedge clk);
    checkOutput("idle out_valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: A held, B in skid, C stalled, then all drain in order.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 64'hA, 64'd4, 5'd1);
    @(negedge clk);
    checkOutput("bp A held", out_result, 64'hA0);
    checkOutput("bp in_ready after A", {63'd0, in_ready}, 64'd1);
    applyStimulus(1'b1, 3'b001, 64'hB0, 64'd4, 5'd2);
    @(negedge clk);
    checkOutput("bp in_ready skid full", {63'd0, in_ready}, 64'd0);
    checkOutput("bp A stable", out_result, 64'hA0);
    applyStimulus(1'b1, 3'b100, 64'hC, 64'd0, 5'd3);
    @(negedge clk);
    checkOutput("bp C stalled", {63'd0, in_ready}, 64'd0);
    checkOutput("bp A rd stable", {59'd0, out_rd}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp B out", out_result, 64'hB);
    checkOutput("bp B rd", {59'd0, out_rd}, 64'd2);
    checkOutput("bp in_ready after reload", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, '0, '0, '0);
    checkOutput("bp C out", out_result, 64'hC);
    checkOutput("bp C rd", {59'd0, out_rd}, 64'd3);
    checkOutput("bp C valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    checkOutput("bp drained", {63'd0, out_valid}, 64'd0);

    // Flush with main and skid full while a third op is offered.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 64'h1, 64'd1, 5'd4);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 64'h1, 64'd2, 5'd5);
    @(negedge clk);
    applyStimulus(1'b1, 3'b000, 64'h1, 64'd3, 5'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, '0);
    out_ready = 1'b1;
    checkOutput("flush out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    checkOutput("flush nothing reappears", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a stall, with an illegal op held in main.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'b011, 64'h5, 64'd0, 5'd7);
    @(negedge clk);
    checkOutput("stall illegal err", {63'd0, out_err}, 64'd1);
    checkOutput("stall illegal result", out_result, 64'd0);
    applyStimulus(1'b1, 3'b000, 64'h3, 64'd1, 5'd8);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 3'b000, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst out_err", {63'd0, out_err}, 64'd0);
    checkOutput("midrst out_rd", {59'd0, out_rd}, 64'd0);
    checkOutput("midrst out_result", out_result, 64'd0);
    checkOutput("midrst in_ready", {63'd0, in_ready}, 64'd1);

    // Randomized traffic against an ordered queue of expected results.
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        acc;
      logic        drn;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [2:0]  op;
      logic [4:0]  rd;
      checkOutput("rand out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
      checkOutput("rand in_ready", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
      if (model_q.size() > 0) begin
        checkOutput("rand result", out_result, model_q[0].result);
        checkOutput("rand rd", {59'd0, out_rd}, {59'd0, model_q[0].rd});
        checkOutput("rand err", {63'd0, out_err}, {63'd0, model_q[0].err});
      end
      op = 3'($urandom_range(0, 7));
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      rd = 5'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, op, r1, r2, rd);
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      acc = in_valid && (model_q.size() < 2);
      drn = out_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (drn) void'(model_q.pop_front());
        if (acc) model_q.push_back(refShift(op, r1, r2, rd));
      end
      @(negedge clk);
    end
    flush = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
